// File: rtl/mem_dados_arbiter.sv
// Round-robin arbiter for the single-port data memory: port 0 = nRisc load/store, port 1 = loader/debug.
// Optional grant/conflict statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_dados_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuGnt,
  output logic              CpuRValid,
  output logic [DATA_W-1:0] CpuRData,
  input  logic              ExtReq,
  input  logic              ExtWe,
  input  logic [ADDR_W-1:0] ExtAddr,
  input  logic [DATA_W-1:0] ExtWData,
  output logic              ExtGnt,
  output logic              ExtRValid,
  output logic [DATA_W-1:0] ExtRData,
  output logic [ADDR_W-1:0] MemEndereco,
  output logic [DATA_W-1:0] MemDadoEscr,
  output logic              MemWrite,
  output logic              MemRead,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]       CpuGntCount,
  output logic [15:0]       ExtGntCount,
  output logic [15:0]       ConflictCount,
`endif
  input  logic [DATA_W-1:0] MemDadoLido
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RDONE} stateT;

  localparam logic [2:0] latInit = 3'(RD_LAT);

  stateT             state, nextState;
  logic              owner;    // port that owns the access in flight: 0 = Cpu, 1 = Ext
  logic              isWrite;
  logic              rrExt;    // round-robin pointer: 1 = Ext wins the next tie
  logic [2:0]        latCnt;
  logic              accept, winner, winWe;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winWData;

  // RDONE arbitrates like IDLE so a waiting request issues with no idle gap.
  assign accept   = ((state == IDLE) || (state == RDONE)) && (CpuReq || ExtReq);
  assign winner   = (CpuReq && ExtReq) ? rrExt : ExtReq;
  assign winWe    = winner ? ExtWe    : CpuWe;
  assign winAddr  = winner ? ExtAddr  : CpuAddr;
  assign winWData = winner ? ExtWData : CpuWData;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves nextState unassigned (no latch).
    nextState = state;
    case (state)
      IDLE, RDONE: nextState = accept ? ISSUE : IDLE;
      ISSUE:       nextState = isWrite ? IDLE : RWAIT;
      RWAIT:       nextState = (latCnt == 3'd1) ? RDONE : RWAIT;
      default:     nextState = IDLE;
    endcase
  end

  always_comb begin
    CpuGnt    = (state == ISSUE) && !owner;
    ExtGnt    = (state == ISSUE) &&  owner;
    MemWrite  = (state == ISSUE) &&  isWrite;
    MemRead   = (state == ISSUE) && !isWrite;
    CpuRValid = (state == RDONE) && !owner;
    ExtRValid = (state == RDONE) &&  owner;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      owner       <= 1'b0;
      isWrite     <= 1'b0;
      rrExt       <= 1'b0;
      latCnt      <= '0;
      MemEndereco <= '0;
      MemDadoEscr <= '0;
      CpuRData    <= '0;
      ExtRData    <= '0;
    end else begin
      if (accept) begin
        owner       <= winner;
        isWrite     <= winWe;
        MemEndereco <= winAddr;
        MemDadoEscr <= winWData;
        rrExt       <= ~winner;
      end
      if (state == ISSUE && !isWrite) latCnt <= latInit;
      else if (state == RWAIT)        latCnt <= latCnt - 3'd1;
      if (state == RWAIT && latCnt == 3'd1) begin
        if (owner) ExtRData <= MemDadoLido;
        else       CpuRData <= MemDadoLido;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Counters advance on the accept edge and stick at 0xFFFF.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      CpuGntCount   <= '0;
      ExtGntCount   <= '0;
      ConflictCount <= '0;
    end else if (accept) begin
      if (!winner && CpuGntCount != 16'hFFFF) CpuGntCount <= CpuGntCount + 16'd1;
      if ( winner && ExtGntCount != 16'hFFFF) ExtGntCount <= ExtGntCount + 16'd1;
      if (CpuReq && ExtReq && ConflictCount != 16'hFFFF) ConflictCount <= ConflictCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dados_arbiter.sv
// Self-checking bench for mem_dados_arbiter: transaction-schedule reference model plus directed literals.
// Build with MEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_mem_dados_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic       Clock = 1'b0, Reset = 1'b0;
  logic       CpuReq = 1'b0, CpuWe = 1'b0, ExtReq = 1'b0, ExtWe = 1'b0;
  logic [7:0] CpuAddr = '0, CpuWData = '0, ExtAddr = '0, ExtWData = '0;
  logic       CpuGnt, CpuRValid, ExtGnt, ExtRValid, MemWrite, MemRead;
  logic [7:0] CpuRData, ExtRData, MemEndereco, MemDadoEscr, MemDadoLido;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] CpuGntCount, ExtGntCount, ConflictCount;
`endif

  int nPass = 0, nTotal = 0, cyc = 0;

  mem_dados_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuRValid(CpuRValid), .CpuRData(CpuRData),
    .ExtReq(ExtReq), .ExtWe(ExtWe), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
    .ExtGnt(ExtGnt), .ExtRValid(ExtRValid), .ExtRData(ExtRData),
    .MemEndereco(MemEndereco), .MemDadoEscr(MemDadoEscr),
    .MemWrite(MemWrite), .MemRead(MemRead),
`ifdef MEM_ARB_STATS_EN
    .CpuGntCount(CpuGntCount), .ExtGntCount(ExtGntCount), .ConflictCount(ConflictCount),
`endif
    .MemDadoLido(MemDadoLido)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

  // Memory: contents start as initVal(addr); data is valid RD_LAT cycles after the read edge,
  // and reads of a wrong cycle return the complement so they cannot match by accident.
  logic [7:0] mem [256];
  bit         written [256];
  logic [7:0] rdPipe [RD_LAT];
  always @(posedge Clock) begin
    logic [7:0] d;
    d = written[MemEndereco] ? mem[MemEndereco] : initVal(MemEndereco);
    if (MemWrite) begin
      mem[MemEndereco]     <= MemDadoEscr;
      written[MemEndereco] <= 1'b1;
    end
    rdPipe[0] <= MemRead ? d : ~d;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign MemDadoLido = rdPipe[RD_LAT-1];

  function automatic logic [7:0] memAt(input logic [7:0] a);
    return written[a] ? mem[a] : initVal(a);
  endfunction

  // Reference model: each accepted request books its visible effects into a per-cycle schedule.
  typedef struct packed {
    logic       issue;
    logic [1:0] gnt;
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] rv;
    logic [7:0] rdata;
  } evT;

  evT         sched [int];
  logic [7:0] refMem [int];
  int         nextArb = 0;
  logic       rr = 1'b0;
  logic [7:0] hAddr = '0, hWd = '0, hR0 = '0, hR1 = '0;
  int         mCpuCnt = 0, mExtCnt = 0, mConf = 0;

  function automatic logic [7:0] modelMem(input logic [7:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : initVal(a);
  endfunction

  task automatic modelAccept();
    logic w, we;
    logic [7:0] a, d;
    evT ev;
    w  = (CpuReq && ExtReq) ? rr : ExtReq;
    we = w ? ExtWe : CpuWe;
    a  = w ? ExtAddr : CpuAddr;
    d  = w ? ExtWData : CpuWData;
    ev = '0;
    ev.issue = 1'b1; ev.gnt[w] = 1'b1; ev.wr = we; ev.rd = !we; ev.addr = a; ev.wdata = d;
    sched[cyc+1] = ev;
    if (we) begin
      refMem[int'(a)] = d;
      nextArb = cyc + 2;
    end else begin
      ev = '0;
      ev.rv[w] = 1'b1;
      ev.rdata = modelMem(a);
      sched[cyc+RD_LAT+2] = ev;
      nextArb = cyc + RD_LAT + 2;
    end
    rr = !w;
    if (!w && mCpuCnt < 65535) mCpuCnt++;
    if ( w && mExtCnt < 65535) mExtCnt++;
    if (CpuReq && ExtReq && mConf < 65535) mConf++;
  endtask

  always @(negedge Clock) begin
    evT e;
    e = '0;
    if (!Reset) begin
      sched.delete();
      nextArb = 0; rr = 1'b0;
      hAddr = '0; hWd = '0; hR0 = '0; hR1 = '0;
      mCpuCnt = 0; mExtCnt = 0; mConf = 0;
    end else if (sched.exists(cyc)) begin
      e = sched[cyc];
      sched.delete(cyc);
      if (e.issue) begin hAddr = e.addr; hWd = e.wdata; end
      if (e.rv[0]) hR0 = e.rdata;
      if (e.rv[1]) hR1 = e.rdata;
    end
    check("CpuGnt", CpuGnt, e.gnt[0]);
    check("ExtGnt", ExtGnt, e.gnt[1]);
    check("MemWrite", MemWrite, e.wr);
    check("MemRead", MemRead, e.rd);
    check("MemEndereco", MemEndereco, hAddr);
    check("MemDadoEscr", MemDadoEscr, hWd);
    check("CpuRValid", CpuRValid, e.rv[0]);
    check("ExtRValid", ExtRValid, e.rv[1]);
    check("CpuRData", CpuRData, hR0);
    check("ExtRData", ExtRData, hR1);
`ifdef MEM_ARB_STATS_EN
    check("CpuGntCount", CpuGntCount, mCpuCnt);
    check("ExtGntCount", ExtGntCount, mExtCnt);
    check("ConflictCount", ConflictCount, mConf);
`endif
    if (Reset && cyc >= nextArb && (CpuReq || ExtReq)) modelAccept();
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin CpuReq = req; CpuWe = we; CpuAddr = a; CpuWData = d; end
    else        begin ExtReq = req; ExtWe = we; ExtAddr = a; ExtWData = d; end
  endtask

  function automatic logic gntOf(input int p);
    return (p == 0) ? CpuGnt : ExtGnt;
  endfunction

  // Random requester: holds each request until granted, occasionally withdraws early.
  task automatic portDriver(input int p, input int nTx);
    for (int t = 0; t < nTx; t++) begin
      int waited, quitAt;
      bit granted, quit;
      repeat ($urandom_range(0, 4)) tick();
      drive(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      quitAt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : 1000;
      waited  = 0;
      granted = 0;
      quit    = 0;
      while (!granted && !quit && waited < 100) begin
        @(negedge Clock);
        if (gntOf(p)) granted = 1;
        else if (waited >= quitAt) quit = 1;
        waited++;
      end
      if (!granted && !quit) check((p == 0) ? "cpuGntTimeout" : "extGntTimeout", 0, 1);
      tick();
      if (quit && gntOf(p)) tick();
      drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", nPass, nTotal);
    $fatal(1);
  end

  initial begin
    int   nG, gntSeen;
    logic order [4];
    int   gcyc [4];

    repeat (2) @(negedge Clock);
    check("rstCpuGnt", CpuGnt, 0);
    check("rstMemRead", MemRead, 0);
    check("rstMemEndereco", MemEndereco, 8'h00);
    tick();
    Reset = 1'b1;

    // Continuous contention on reads: strictly alternating grants, Cpu first.
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    nG = 0;
    for (int w = 0; w < 60 && nG < 4; w++) begin
      @(negedge Clock);
      if (CpuGnt || ExtGnt) begin order[nG] = ExtGnt; gcyc[nG] = cyc; nG++; end
    end
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("contGrants", nG, 4);
    for (int i = 0; i < 4; i++) check($sformatf("contOrder%0d", i), order[i], i % 2);
    for (int i = 0; i < 3; i++) check($sformatf("contGap%0d", i), gcyc[i+1] - gcyc[i], RD_LAT + 2);
    repeat (3) tick();
`ifdef MEM_ARB_STATS_EN
    check("statCpu", CpuGntCount, 2);
    check("statExt", ExtGntCount, 2);
    check("statConflict", ConflictCount, 4);
`endif

    // Cpu write 0x10 <= 0xA5.
    tick();
    drive(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge Clock);
    @(negedge Clock);
    check("wrGnt", CpuGnt, 1);
    check("wrStrobe", MemWrite, 1);
    check("wrNoRead", MemRead, 0);
    check("wrAddr", MemEndereco, 8'h10);
    check("wrData", MemDadoEscr, 8'hA5);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("mem10", memAt(8'h10), 8'hA5);

    // Cpu read of 0x10 with a one-cycle Ext request pulse during RWAIT.
    tick();
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge Clock);
    @(negedge Clock);
    check("rdGnt", CpuGnt, 1);
    check("rdStrobe", MemRead, 1);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b1, 8'h33, 8'h44);
    @(negedge Clock);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge Clock);
    check("rdValid", CpuRValid, 1);
    check("rdData", CpuRData, 8'hA5);
    check("rdExtQuiet", ExtRValid, 0);
    @(negedge Clock);
    check("withdrawNoGnt", ExtGnt, 0);

    // Ext write to 0xFF raised during a Cpu read: issues right after RDONE.
    tick();
    drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge Clock);
    tick();
    drive(1, 1'b1, 1'b1, 8'hFF, 8'h5A);
    @(negedge Clock);
    check("hdCpuGnt", CpuGnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge Clock);
    @(negedge Clock);
    check("hdCpuValid", CpuRValid, 1);
    check("hdCpuData", CpuRData, 8'hE3);
    check("hdExtWait", ExtGnt, 0);
    @(negedge Clock);
    check("hdExtGnt", ExtGnt, 1);
    check("hdExtWr", MemWrite, 1);
    check("hdExtAddr", MemEndereco, 8'hFF);
    check("hdExtData", MemDadoEscr, 8'h5A);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("memFF", memAt(8'hFF), 8'h5A);

    // Asynchronous reset in the middle of RWAIT discards the read.
    tick();
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge Clock);
    @(negedge Clock);
    check("rmGnt", CpuGnt, 1);
    @(posedge Clock);
    #3;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    Reset = 1'b0;
    #1;
    check("rmCpuGnt", CpuGnt, 0);
    check("rmMemRead", MemRead, 0);
    check("rmCpuRValid", CpuRValid, 0);
    check("rmAddr", MemEndereco, 8'h00);
    check("rmWData", MemDadoEscr, 8'h00);
    check("rmCpuRData", CpuRData, 8'h00);
    check("rmExtRData", ExtRData, 8'h00);
    repeat (2) @(negedge Clock);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("rmNoValid", CpuRValid, 0);
    end
    tick();
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    gntSeen = 0;
    for (int w = 0; w < 5 && gntSeen == 0; w++) begin
      @(negedge Clock);
      if (ExtGnt) gntSeen = 1;
    end
    check("rmExtGnt", gntSeen, 1);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge Clock);
    @(negedge Clock);
    check("rmExtValid", ExtRValid, 1);
    check("rmExtData", ExtRData, 8'hA5);

    // Randomized traffic from both ports, checked cycle by cycle against the model.
    tick();
    fork
      portDriver(0, 150);
      portDriver(1, 150);
    join
    repeat (6) tick();

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule

// File: doc/mem_dados_arbiter.md
Name: mem_dados_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 is the nRisc load/store path and port 1 is the external loader/debug master.
- Sits between both masters and the data memory instance.
- Drives the memory's address, write-data, MemWrite and MemRead lines.
- Returns read data with a per-port valid pulse.
- Round-robin fairness; one access in flight at a time.

Parameters:
- ADDR_W, 8, address width (data memory is 256 entries)
- DATA_W, 8, data width
- RD_LAT, 1, cycles from MemRead issue cycle until MemDadoLido is valid (1..7)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- CpuReq  in  1  port 0 access request, held until CpuGnt
- CpuWe  in  1  1 = write, 0 = read; qualified by CpuReq
- CpuAddr  in  ADDR_W  port 0 address
- CpuWData  in  DATA_W  port 0 write data
- CpuGnt  out  1  one-cycle pulse: port 0 request accepted and issued
- CpuRValid  out  1  one-cycle pulse: CpuRData holds read result
- CpuRData  out  DATA_W  port 0 read data, held until the next port 0 read completes
- ExtReq, ExtWe, ExtAddr, ExtWData, ExtGnt, ExtRValid, ExtRData  same as the Cpu* set, for port 1
- MemEndereco  out  ADDR_W  memory address
- MemDadoEscr  out  DATA_W  memory write data
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read strobe
- MemDadoLido  in  DATA_W  memory read data

Behaviour:
- Reset (Reset=0) clears immediately, regardless of Clock:
  - all outputs to 0
  - FSM to IDLE
  - latency counter to 0
  - RR pointer favours port 0
- FSM states: IDLE, ISSUE, RWAIT, RDONE.
- IDLE: at a rising edge with any Req=1:
  - Winner: the only requester; if both, the one the RR pointer favours.
  - Register winner's Addr/WData into MemEndereco/MemDadoEscr.
  - Set MemWrite=We or MemRead=~We.
  - Set winner's Gnt=1; move to ISSUE.
  - RR pointer flips to favour the loser.
  - No Req: remain IDLE, outputs 0.
- ISSUE: exactly one cycle, with Gnt and the selected strobe high; memory samples at the edge ending this cycle.
  - Write: go to IDLE; Gnt and MemWrite drop.
  - Read: MemRead drops; counter loads RD_LAT; go to RWAIT.
- RWAIT: counter decrements each cycle. In the cycle where counter=1, MemDadoLido is valid; at the edge ending that cycle:
  - capture MemDadoLido into the owner's RData
  - assert the owner's RValid
  - go to RDONE
- RDONE: one cycle with RValid=1.
  - Arbitration per the IDLE rules is evaluated at the edge ending RDONE, so a new ISSUE follows with no idle gap.
  - Going to IDLE at that edge takes effect only when no Req is pending.
- Timing: write occupies 2 cycles (accept edge + ISSUE). Read latency from accept edge to RValid cycle = RD_LAT+2 cycles.
- Handshake rules:
  - Requester holds Req/We/Addr/WData stable from assertion through its Gnt cycle.
  - A requester may reassert in the cycle after Gnt.
  - Dropping Req before Gnt withdraws the request with no side effect.
- MemEndereco/MemDadoEscr hold their last value outside ISSUE. Only strobes return to 0.
- Simultaneous requests: RR order is strictly alternating under continuous contention; no port waits more than one access.
- A request arriving during ISSUE/RWAIT/RDONE waits; it is not lost.
- Reset mid-read: the pending read is discarded; no RValid is ever produced for it.
- Address wrap: none inside the block; addresses pass through unchanged (0xFF is legal).

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Enabled: adds three outputs:
  - CpuGntCount (16 bits), +1 per CpuGnt
  - ExtGntCount (16 bits), +1 per ExtGnt
  - ConflictCount (16 bits), +1 per accept edge where both Req=1
- All counters saturate at 0xFFFF and clear on Reset.
- Disabled: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-operation: Reset=0 asynchronously mid-RWAIT → all outputs 0 immediately; after release, no RValid appears; next request from either port is accepted normally.
- CPU write: CpuReq=1, CpuWe=1, CpuAddr=0x10, CpuWData=0xA5 → next cycle CpuGnt=1, MemWrite=1, MemEndereco=0x10, MemDadoEscr=0xA5; memory[0x10]=0xA5 afterwards.
- CPU read, RD_LAT=1: memory[0x10]=0xA5; CpuReq=1, CpuWe=0, CpuAddr=0x10 at edge k → CpuGnt and MemRead in cycle k+1; CpuRValid=1 with CpuRData=0xA5 in cycle k+3; ExtRValid stays 0.
- Contention: both Req held continuously, reads, Cpu Addr 0x01, Ext Addr 0x02 → grants alternate Cpu, Ext, Cpu, Ext, starting with Cpu after reset; back-to-back ISSUE after each RDONE.
- Boundary/withdraw: ExtReq pulses 1 cycle during a Cpu RWAIT, then drops → no ExtGnt. ExtReq write to address 0xFF while held → accepted after RDONE; memory[0xFF] written.
- MEM_ARB_STATS_EN: 3 contended accesses plus 1 lone Cpu access → CpuGntCount=2 (or 3 per RR order), ExtGntCount totals 4 combined with CpuGntCount, ConflictCount=3.
